// File: rtl/avr_irq_ctrl.sv
// Interrupt controller for the avr core: N maskable channels with edge/level mode, prioritised onto intr/vect.
// Optional macro IRQ_ROTATE_EN selects round-robin arbitration instead of fixed lowest-index priority.
module avr_irq_ctrl #(
  parameter int          CHANNELS = 8,
  parameter int          VW       = 3,
  parameter logic [15:0] BASE     = 16'h0058
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [15:0]         a,
  input  logic [7:0]          o,
  input  logic                w,
  input  logic                r,
  output logic [7:0]          p,
  output logic                sel,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic                iack,
  output logic                intr,
  output logic [VW-1:0]       vect
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t              state_reg, state_next;
  logic [CHANNELS-1:0] s1_reg, s2_reg, s3_reg;
  logic [CHANNELS-1:0] mask_reg, mask_next;
  logic [CHANNELS-1:0] pend_reg, pend_next;
  logic [CHANNELS-1:0] mode_reg, mode_next;
  logic [CHANNELS-1:0] cand;
  logic [VW-1:0]       vect_reg, vect_next, winner;
  logic [15:0]         offset;
  logic                wr_mask, wr_pend, wr_mode, ack_take, any_req;
  logic [7:0]          mask8, pend8, mode8, stat8;

  assign offset   = a - BASE;
  assign sel      = (offset < 16'd4);
  assign wr_mask  = w & sel & (offset[1:0] == 2'd0);
  assign wr_pend  = w & sel & (offset[1:0] == 2'd1);
  assign wr_mode  = w & sel & (offset[1:0] == 2'd2);
  assign ack_take = (state_reg == REQ) & iack;
  assign cand     = pend_reg & mask_reg;
  assign any_req  = |cand;

  assign mask_next = wr_mask ? o[CHANNELS-1:0] : mask_reg;
  assign mode_next = wr_mode ? o[CHANNELS-1:0] : mode_reg;

  // Edge channels: a set on the same cycle as a clear still wins, so no edge is lost.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pend
      logic rise, clr;
      assign rise = s2_reg[gi] & ~s3_reg[gi];
      assign clr  = (wr_pend & o[gi]) | (ack_take & (vect_reg == VW'(gi)));
      assign pend_next[gi] = mode_reg[gi] ? (rise | (pend_reg[gi] & ~clr)) : s2_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      s3_reg   <= '0;
      mask_reg <= '0;
      pend_reg <= '0;
      mode_reg <= '1;
    end else begin
      s1_reg   <= irq_in;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      mask_reg <= mask_next;
      pend_reg <= pend_next;
      mode_reg <= mode_next;
    end
  end

`ifdef IRQ_ROTATE_EN
  logic [VW-1:0] ptr_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ptr_reg <= '0;
    else if (ack_take)
      ptr_reg <= (vect_reg == VW'(CHANNELS - 1)) ? '0 : vect_reg + 1'b1;
  end

  // Walk downward from the farthest offset so the nearest candidate after ptr_reg wins.
  always_comb begin
    int idx;
    winner = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (cand[idx]) winner = VW'(idx);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (cand[k]) winner = VW'(k);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      vect_reg  <= '0;
    end else begin
      state_reg <= state_next;
      vect_reg  <= vect_next;
    end
  end

  // The latched channel is held in REQ; it is abandoned only if it loses its mask or pending bit.
  always_comb begin
    state_next = state_reg;
    vect_next  = vect_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = REQ;
          vect_next  = winner;
        end
      end
      REQ: begin
        if (iack)
          state_next = HOLD;
        else if (!(mask_next[vect_reg] & pend_next[vect_reg]))
          state_next = IDLE;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    intr = (state_reg == REQ);
    vect = vect_reg;
  end

  always_comb begin
    mask8 = '0;
    pend8 = '0;
    mode8 = '0;
    stat8 = '0;
    mask8[CHANNELS-1:0] = mask_reg;
    pend8[CHANNELS-1:0] = pend_reg;
    mode8[CHANNELS-1:0] = mode_reg;
    stat8[7]            = intr;
    stat8[VW-1:0]       = vect_reg;
    p = '0;
    if (sel) begin
      case (offset[1:0])
        2'd0:    p = mask8;
        2'd1:    p = pend8;
        2'd2:    p = mode8;
        default: p = stat8;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Directed bench for avr_irq_ctrl: latency, priority, level mode, masking, W1C races, register window.
module tb_avr_irq_ctrl;

  localparam logic [15:0] BASE = 16'h0058;

  logic        clock, reset_n;
  logic [15:0] a;
  logic [7:0]  o;
  logic        w, r, iack;
  logic [7:0]  irq_in;
  logic [7:0]  p;
  logic        sel, intr;
  logic [2:0]  vect;

  logic [2:0]  irq3;
  logic [7:0]  p3;
  logic        sel3, intr3;
  logic [1:0]  vect3;

  int n_vec = 0;
  int n_err = 0;

  avr_irq_ctrl #(.CHANNELS(8), .VW(3), .BASE(BASE)) dut (
    .clock(clock), .reset_n(reset_n), .a(a), .o(o), .w(w), .r(r),
    .p(p), .sel(sel), .irq_in(irq_in), .iack(iack), .intr(intr), .vect(vect)
  );

  avr_irq_ctrl #(.CHANNELS(3), .VW(2), .BASE(BASE)) dut3 (
    .clock(clock), .reset_n(reset_n), .a(a), .o(o), .w(w), .r(r),
    .p(p3), .sel(sel3), .irq_in(irq3), .iack(iack), .intr(intr3), .vect(vect3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] d);
    a = addr; o = d; w = 1'b1;
    tick();
    w = 1'b0; a = 16'h0000; o = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    a = addr; r = 1'b1;
    #1;
    check(tag, {8'h00, p}, {8'h00, exp});
    r = 1'b0; a = 16'h0000;
  endtask

  task automatic ack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; a = '0; o = '0; w = 1'b0; r = 1'b0; iack = 1'b0;
    irq_in = '0; irq3 = '0;
    repeat (3) tick();
    check("rst_intr", {15'd0, intr}, 16'd0);
    check("rst_vect", {13'd0, vect}, 16'd0);
    reset_n = 1'b1;
    tick();
    rd_chk("rst_imask", BASE + 16'd0, 8'h00);
    rd_chk("rst_ipend", BASE + 16'd1, 8'h00);
    rd_chk("rst_imode", BASE + 16'd2, 8'hFF);
    rd_chk("rst_istat", BASE + 16'd3, 8'h00);

    // 1: single edge request, 4-edge latency, ack clears pending
    wr(BASE, 8'h01);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    tick(); tick();
    check("t1_intr_e3", {15'd0, intr}, 16'd0);
    rd_chk("t1_ipend_e3", BASE + 16'd1, 8'h01);
    tick();
    check("t1_intr_e4", {15'd0, intr}, 16'd1);
    check("t1_vect", {13'd0, vect}, 16'd0);
    rd_chk("t1_istat", BASE + 16'd3, 8'h80);
    ack();
    check("t1_intr_ack", {15'd0, intr}, 16'd0);
    rd_chk("t1_ipend_ack", BASE + 16'd1, 8'h00);
    tick();
    check("t1_intr_hold", {15'd0, intr}, 16'd0);

    // 2: simultaneous 5 and 2, lower index first
    wr(BASE, 8'hFF);
    irq_in = 8'h24;
    repeat (4) tick();
    check("t2_intr_a", {15'd0, intr}, 16'd1);
    check("t2_vect_a", {13'd0, vect}, 16'd2);
    ack();
    rd_chk("t2_ipend", BASE + 16'd1, 8'h20);
    tick();
    check("t2_intr_gap", {15'd0, intr}, 16'd0);
    tick();
    check("t2_intr_b", {15'd0, intr}, 16'd1);
    check("t2_vect_b", {13'd0, vect}, 16'd5);
    ack();
    irq_in = 8'h00;
    tick(); tick();
    rd_chk("t2_ipend_end", BASE + 16'd1, 8'h00);

    // 3: level mode on channel 3 re-asserts until the line drops
    wr(BASE + 16'd2, 8'hF7);
    wr(BASE, 8'h08);
    irq_in = 8'h08;
    repeat (4) tick();
    check("t3_intr", {15'd0, intr}, 16'd1);
    check("t3_vect", {13'd0, vect}, 16'd3);
    wr(BASE + 16'd1, 8'h08);
    check("t3_w1c_lvl_intr", {15'd0, intr}, 16'd1);
    rd_chk("t3_w1c_lvl_pend", BASE + 16'd1, 8'h08);
    ack();
    check("t3_intr_ack", {15'd0, intr}, 16'd0);
    tick(); tick();
    check("t3_intr_again", {15'd0, intr}, 16'd1);
    check("t3_vect_again", {13'd0, vect}, 16'd3);
    irq_in = 8'h00;
    tick();
    check("t3_intr_drop1", {15'd0, intr}, 16'd1);
    tick(); tick();
    check("t3_intr_drop3", {15'd0, intr}, 16'd0);
    rd_chk("t3_ipend_drop", BASE + 16'd1, 8'h00);
    wr(BASE + 16'd2, 8'hFF);

    // 4: masking the presented channel withdraws intr but keeps pending
    wr(BASE, 8'h02);
    irq_in = 8'h02; tick(); irq_in = 8'h00;
    repeat (3) tick();
    check("t4_intr", {15'd0, intr}, 16'd1);
    check("t4_vect", {13'd0, vect}, 16'd1);
    wr(BASE, 8'h00);
    check("t4_intr_masked", {15'd0, intr}, 16'd0);
    rd_chk("t4_ipend", BASE + 16'd1, 8'h02);
    wr(BASE, 8'h02);
    tick();
    check("t4_intr_reen", {15'd0, intr}, 16'd1);
    check("t4_vect_reen", {13'd0, vect}, 16'd1);
    ack();
    tick(); tick();
    rd_chk("t4_ipend_end", BASE + 16'd1, 8'h00);

    // 5: W1C racing a new edge on channel 4; stray iack outside REQ
    wr(BASE, 8'h00);
    irq_in = 8'h10; tick(); irq_in = 8'h00;
    tick(); tick();
    rd_chk("t5_ipend_first", BASE + 16'd1, 8'h10);
    irq_in = 8'h10; tick(); irq_in = 8'h00;
    tick();
    wr(BASE + 16'd1, 8'h10);
    rd_chk("t5_ipend_race", BASE + 16'd1, 8'h10);
    ack();
    rd_chk("t5_ipend_iack_idle", BASE + 16'd1, 8'h10);
    wr(BASE + 16'd1, 8'h10);
    rd_chk("t5_ipend_w1c", BASE + 16'd1, 8'h00);

    // 6: register window decode and narrow instance
    rd_chk("t6_imode", BASE + 16'd2, 8'hFF);
    a = BASE + 16'd2; #1;
    check("t6_sel_in", {15'd0, sel}, 16'd1);
    check("t6_p3_imode", {8'h00, p3}, 16'h0007);
    check("t6_sel3_in", {15'd0, sel3}, 16'd1);
    a = BASE + 16'd4; #1;
    check("t6_sel_above", {15'd0, sel}, 16'd0);
    check("t6_p_above", {8'h00, p}, 16'h0000);
    a = BASE - 16'd1; #1;
    check("t6_sel_below", {15'd0, sel}, 16'd0);
    a = 16'h0000;

    // reset while presenting a request
    wr(BASE, 8'h01);
    irq_in = 8'h01; tick(); irq_in = 8'h00;
    repeat (3) tick();
    check("rr_intr_pre", {15'd0, intr}, 16'd1);
    reset_n = 1'b0; #1;
    check("rr_intr_async", {15'd0, intr}, 16'd0);
    tick();
    reset_n = 1'b1;
    tick();
    rd_chk("rr_ipend", BASE + 16'd1, 8'h00);
    rd_chk("rr_imask", BASE + 16'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
